// File: rtl/mealy_table_fsm.sv
// mealy_table_fsm: table-driven Mealy state machine with a programmable
// transition table held in registers.
//
// Each table entry is addressed by {pstate, in} and holds {next_state, out}.
// The out field drives z combinationally. When en=1, the next_state field is
// loaded into pstate on the clock edge.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; clears state, counter and table
//   en         run enable; pstate advances only when en=1
//   clr        synchronous return to state 0 (table and counter untouched)
//   in         FSM input vector
//   prog_we    table write strobe
//   prog_addr  table address {state, in}
//   prog_data  table entry {next_state, out}
//   z          combinational Mealy output
//   pstate     present state
//   trans_cnt  saturating count of state changes
module mealy_table_fsm #(
  parameter int unsigned SW = 2,
  parameter int unsigned IW = 2,
  parameter int unsigned OW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [IW-1:0]    in,
  input  logic             prog_we,
  input  logic [SW+IW-1:0] prog_addr,
  input  logic [SW+OW-1:0] prog_data,
  output logic [OW-1:0]    z,
  output logic [SW-1:0]    pstate,
  output logic [7:0]       trans_cnt
);

  localparam int AW    = SW + IW;
  localparam int DW    = SW + OW;
  localparam int Depth = 2 ** AW;

  logic [DW-1:0] tbl_q [Depth];
  logic [SW-1:0] pstate_q;
  logic [7:0]    cnt_q;

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_entry;
  logic [SW-1:0] next_state;

  // Read path sees the pre-edge table contents, so a write to the entry
  // currently addressed takes effect only from the following cycle.
  always_comb begin
    rd_addr    = {pstate_q, in};
    rd_entry   = tbl_q[rd_addr];
    next_state = rd_entry[DW-1:OW];
    z          = rd_entry[OW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      if (prog_we) begin
        tbl_q[prog_addr] <= prog_data;
      end
      if (clr) begin
        pstate_q <= '0;
      end else if (en) begin
        pstate_q <= next_state;
        // Only real state changes count; self-loops leave the counter alone.
        if ((next_state != pstate_q) && (cnt_q != 8'hFF)) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign pstate    = pstate_q;
  assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_mealy_table_fsm.sv
module tb_mealy_table_fsm;

  localparam int SW = 2;
  localparam int IW = 2;
  localparam int OW = 1;

  logic             clk = 1'b0;
  logic             run = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [IW-1:0]    in = '0;
  logic             prog_we = 1'b0;
  logic [SW+IW-1:0] prog_addr = '0;
  logic [SW+OW-1:0] prog_data = '0;
  logic [OW-1:0]    z;
  logic [SW-1:0]    pstate;
  logic [7:0]       trans_cnt;

  mealy_table_fsm #(.SW(SW), .IW(IW), .OW(OW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .in        (in),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .z         (z),
    .pstate    (pstate),
    .trans_cnt (trans_cnt)
  );

  initial forever begin
    #5;
    if (run) clk = ~clk;
  end

  typedef struct {
    string         name;
    logic [OW-1:0] z;
    logic [SW-1:0] ps;
    logic [7:0]    cnt;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: pops one expectation per sample strobe and compares.
  initial forever begin
    exp_t e;
    @(chk_ev);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sample_without_expectation: got z=%0d pstate=%0d trans_cnt=%0d",
               z, pstate, trans_cnt);
    end else begin
      e = sb.pop_front();
      if (z !== e.z || pstate !== e.ps || trans_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got z=%0d pstate=%0d trans_cnt=%0d, expected z=%0d pstate=%0d trans_cnt=%0d",
                 e.name, z, pstate, trans_cnt, e.z, e.ps, e.cnt);
      end
    end
  end

  task automatic expect_out(input string name, input logic [OW-1:0] ez,
                            input logic [SW-1:0] eps, input logic [7:0] ecnt);
    exp_t e;
    e.name = name;
    e.z    = ez;
    e.ps   = eps;
    e.cnt  = ecnt;
    sb.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic prog(input logic [SW+IW-1:0] a, input logic [SW+OW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  initial begin
    // Reset with no clock running.
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      in = IW'(i);
      #1;
      expect_out($sformatf("reset_in%0d", i), 1'b0, 2'd0, 8'd0);
    end
    in = 2'b00;
    reset = 1'b0;
    run = 1'b1;
    step();

    // Program-and-run.
    prog(4'b0001, 3'b010);
    in = 2'b01;
    en = 1'b1;
    #1;
    expect_out("run_z_before_edge", 1'b0, 2'd0, 8'd0);
    step();
    en = 1'b0;
    expect_out("run_after_edge", 1'b0, 2'd1, 8'd1);

    // Hold for three edges, then clear with en=1.
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("hold_%0d", i), 1'b0, 2'd1, 8'd1);
    end
    clr = 1'b1;
    en  = 1'b1;
    step();
    clr = 1'b0;
    en  = 1'b0;
    expect_out("clr_to_zero", 1'b0, 2'd0, 8'd1);

    // Read-before-write on the addressed entry.
    in        = 2'b00;
    prog_we   = 1'b1;
    prog_addr = 4'b0000;
    prog_data = 3'b111;
    en        = 1'b1;
    #1;
    expect_out("rbw_old_z", 1'b0, 2'd0, 8'd1);
    step();
    prog_we = 1'b0;
    en      = 1'b0;
    expect_out("rbw_new_z_state_held", 1'b1, 2'd0, 8'd1);
    en = 1'b1;
    step();
    en = 1'b0;
    expect_out("rbw_jump_to_3", 1'b0, 2'd3, 8'd2);

    // Asynchronous reset between edges at pstate=3; a write during reset
    // must be discarded.
    #1 reset = 1'b1;
    #1;
    expect_out("reset_mid_run", 1'b0, 2'd0, 8'd0);
    prog_we   = 1'b1;
    prog_addr = 4'b0000;
    prog_data = 3'b111;
    step();
    prog_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in = IW'(i);
      #1;
      expect_out($sformatf("reset_table_in%0d", i), 1'b0, 2'd0, 8'd0);
    end
    reset = 1'b0;
    in = 2'b00;
    en = 1'b1;
    step();
    en = 1'b0;
    expect_out("after_reset_run_stays0", 1'b0, 2'd0, 8'd0);

    // Saturation: 00 <-> 01 ping-pong on in=00.
    prog(4'b0000, 3'b011);
    prog(4'b0100, 3'b000);
    in = 2'b00;
    #1;
    expect_out("pp_start", 1'b1, 2'd0, 8'd0);
    en = 1'b1;
    repeat (100) step();
    expect_out("pp_100", 1'b1, 2'd0, 8'd100);
    repeat (155) step();
    expect_out("pp_255", 1'b0, 2'd1, 8'd255);
    repeat (45) step();
    expect_out("pp_300_sat", 1'b1, 2'd0, 8'd255);
    clr = 1'b1;
    step();
    clr = 1'b0;
    en  = 1'b0;
    expect_out("clr_keeps_sat_cnt", 1'b1, 2'd0, 8'd255);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
